// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: 2-flop synchroniser, saturating stability counter and
// registered press/release pulses per channel. Optional auto-repeat under DEBOUNCE_AUTOREPEAT_EN.
module multi_debouncer #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] noisy_button,
  output logic [NUM_CH-1:0] button_state,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int            RPT_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW           = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  if (NUM_CH < 1 || NUM_CH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("multi_debouncer: NUM_CH must be 1..32 and DEBOUNCE_CYCLES >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("multi_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          sync_p0, sync_p1;
    logic          sample;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          accept;
    logic          rpt_fire;
    logic          press_q, release_q;

    // Polarity-normalised sample: 1 means pressed.
    assign sample = sync_p1 ^ IDLE_LVL;

    always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      accept  = 1'b0;
      if (sample != state_q) begin
        if (cnt_q >= CNT_LAST) begin
          accept  = 1'b1;
          state_d = ~state_q;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic [RW-1:0] rpt_q, rpt_d;
    logic          phase_q, phase_d;

    // phase 0 waits out the initial delay, phase 1 paces the periodic repeats;
    // nothing fires on the release edge itself.
    always_comb begin
      rpt_d    = '0;
      phase_d  = 1'b0;
      rpt_fire = 1'b0;
      if (state_q && !accept) begin
        phase_d = phase_q;
        if (rpt_q >= (phase_q ? RPT_PER_LAST : RPT_DLY_LAST)) begin
          rpt_fire = 1'b1;
          phase_d  = 1'b1;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rpt_q   <= '0;
        phase_q <= 1'b0;
      end else begin
        rpt_q   <= rpt_d;
        phase_q <= phase_d;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Stage p0/p1: synchroniser; then counter, state and registered pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_p0   <= IDLE_LVL;
        sync_p1   <= IDLE_LVL;
        cnt_q     <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_p0   <= noisy_button[i];
        sync_p1   <= sync_p0;
        cnt_q     <= cnt_d;
        state_q   <= state_d;
        press_q   <= (accept & state_d) | rpt_fire;
        release_q <= accept & ~state_d;
      end
    end

    assign button_state[i]  = state_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: stimulus pushes expected pulse events, a monitor pops them.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] noisy_button = 4'hF;
  logic [3:0] button_state, press_pulse, release_pulse;

  multi_debouncer #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(5), .ACTIVE_LOW(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .noisy_button(noisy_button),
    .button_state(button_state), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] st;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  t0, t1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    e.cyc = c; e.prs = p; e.rel = r; e.st = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a pulse present must match the next expected event.
  initial forever begin
    @(negedge clk);
    if (press_pulse != 4'b0 || release_pulse != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {24'b0, press_pulse, release_pulse}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("event_pulses", {24'b0, press_pulse, release_pulse}, {24'b0, mon_e.prs, mon_e.rel});
        chk("event_state", {28'b0, button_state}, {28'b0, mon_e.st});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {28'b0, button_state}, 32'h0);
    chk("reset_press", {28'b0, press_pulse}, 32'h0);
    chk("reset_release", {28'b0, release_pulse}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Ch0 clean press for 10 cycles then release
    t0 = cyc;
    noisy_button[0] = 1'b0;
    expect_ev(t0 + 7, 4'b0001, 4'b0000, 4'b0001);
    repeat (10) @(negedge clk);
    chk("ch0_held_state", {28'b0, button_state}, 32'h1);
    t1 = cyc;
    noisy_button[0] = 1'b1;
    expect_ev(t1 + 7, 4'b0000, 4'b0001, 4'b0000);
    repeat (12) @(negedge clk);

    // Ch1 glitches: 1 cycle, 4 cycles, then 2-cycle alternation
    noisy_button[1] = 1'b0;
    @(negedge clk);
    noisy_button[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("ch1_after_1cyc_glitch", {31'b0, button_state[1]}, 32'h0);
    noisy_button[1] = 1'b0;
    repeat (4) @(negedge clk);
    noisy_button[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("ch1_after_4cyc_glitch", {31'b0, button_state[1]}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      noisy_button[1] = ~noisy_button[1];
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("ch1_after_alternating", {31'b0, button_state[1]}, 32'h0);

    // Ch0 and ch3 together
    t0 = cyc;
    noisy_button = 4'b0110;
    expect_ev(t0 + 7, 4'b1001, 4'b0000, 4'b1001);
    repeat (10) @(negedge clk);
    t1 = cyc;
    noisy_button = 4'b1111;
    expect_ev(t1 + 7, 4'b0000, 4'b1001, 4'b0000);
    repeat (12) @(negedge clk);

    // Ch2 held, reset mid-count then mid-pulse
    noisy_button[2] = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("rst_midcount_outputs", {20'b0, button_state, press_pulse, release_pulse}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_midcount_held", {20'b0, button_state, press_pulse, release_pulse}, 32'h0);
    t0 = cyc;
    reset_n = 1'b1;
    expect_ev(t0 + 7, 4'b0100, 4'b0000, 4'b0100);
    repeat (7) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("rst_midpulse_outputs", {20'b0, button_state, press_pulse, release_pulse}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_midpulse_held", {20'b0, button_state, press_pulse, release_pulse}, 32'h0);
    t0 = cyc;
    reset_n = 1'b1;
    expect_ev(t0 + 7, 4'b0100, 4'b0000, 4'b0100);
    repeat (6) @(negedge clk);
    chk("rst_no_early_state", {28'b0, button_state}, 32'h0);
    repeat (4) @(negedge clk);
    t1 = cyc;
    noisy_button[2] = 1'b1;
    expect_ev(t1 + 7, 4'b0000, 4'b0100, 4'b0000);
    repeat (12) @(negedge clk);

    // Ch0 long hold: single press, or press plus repeats when auto-repeat is built in
    t0 = cyc;
    noisy_button[0] = 1'b0;
    expect_ev(t0 + 7, 4'b0001, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    for (int k = 0; k < 5; k++) expect_ev(t0 + 27 + 4 * k, 4'b0001, 4'b0000, 4'b0001);
`endif
    repeat (40) @(negedge clk);
    t1 = cyc;
    noisy_button[0] = 1'b1;
    expect_ev(t1 + 7, 4'b0000, 4'b0001, 4'b0000);
    repeat (15) @(negedge clk);

    chk("pending_events", exp_q.size(), 32'h0);
    chk("final_state", {28'b0, button_state}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent button channels (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 5: consecutive stable synchronised samples required to accept a level change (>=2).
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a raw input level of 0 is "pressed"; 0 means a raw level of 1 is "pressed".
REQ-004 Parameter REPEAT_DELAY, default 50: cycles from an accepted press to the first auto-repeat pulse (used only under DEBOUNCE_AUTOREPEAT_EN).
REQ-005 Parameter REPEAT_PERIOD, default 10: cycles between subsequent auto-repeat pulses (used only under DEBOUNCE_AUTOREPEAT_EN).
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 noisy_button  input  NUM_CH  raw asynchronous button levels, one bit per channel.
REQ-009 button_state  output  NUM_CH  debounced level per channel, 1 = pressed (polarity-normalised).
REQ-010 press_pulse  output  NUM_CH  one-cycle pulse on an accepted press, and on auto-repeat when enabled.
REQ-011 release_pulse  output  NUM_CH  one-cycle pulse on an accepted release.

Function
REQ-012 Each channel SHALL pass its noisy_button bit through a 2-flop synchroniser, then normalise polarity per ACTIVE_LOW; channels share no state.
REQ-013 The per-channel counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-014 When the synchronised sample equals button_state, the counter SHALL clear to 0 on that edge.
REQ-015 When the sample differs from button_state, the counter SHALL increment; on the edge where it would reach DEBOUNCE_CYCLES, button_state SHALL toggle and the counter SHALL clear.
REQ-016 Any single sample equal to button_state during counting SHALL restart the count from 0, so glitches of up to DEBOUNCE_CYCLES-1 cycles produce no output.
REQ-017 Latency: a clean input edge SHALL change button_state exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-018 press_pulse[i] SHALL be high for exactly the one cycle following a 0->1 button_state transition; release_pulse[i] SHALL do the same for a 1->0 transition; the two SHALL never be high together on one channel.
REQ-019 Multiple channels changing on the same edge SHALL each produce their own pulses on the same cycle, with no arbitration or loss.
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from noisy_button.

Reset
REQ-021 Asserting reset_n low SHALL immediately, without waiting for clk, force button_state=0, press_pulse=0, release_pulse=0, all counters=0, and both synchroniser stages to the released level (1 if ACTIVE_LOW else 0).
REQ-022 A pulse or debounce in progress when reset asserts SHALL be cancelled; after reset releases, a held button SHALL require a full DEBOUNCE_CYCLES+2 edges before press_pulse is issued.
REQ-023 Reset deassertion SHALL be taken synchronously to clk by the integrating top level; the block SHALL NOT add its own reset synchroniser.

Configuration
REQ-024 With macro DEBOUNCE_AUTOREPEAT_EN defined, each channel SHALL contain a repeat counter; while button_state[i]=1, press_pulse[i] SHALL re-pulse REPEAT_DELAY cycles after the accepted press and every REPEAT_PERIOD cycles after that.
REQ-025 With DEBOUNCE_AUTOREPEAT_EN defined, the repeat counter SHALL clear on release or reset, and a repeat pulse SHALL never coincide with a release_pulse.
REQ-026 Without DEBOUNCE_AUTOREPEAT_EN, no repeat logic SHALL be synthesised, REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and press_pulse SHALL fire exactly once per accepted press.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=5, ACTIVE_LOW=1, 10 ns clock)
REQ-027 Ch0 driven low for 10 cycles then high -> button_state[0] rises 7 edges after the drop, one press_pulse[0]; on release, one release_pulse[0] 7 edges later.
REQ-028 Ch1 low for 1 cycle, then for 4 cycles, then alternating every 2 cycles for 20 cycles -> no pulses and button_state[1] stays 0 throughout.
REQ-029 Ch0 and ch3 driven low on the same edge -> press_pulse equals 4'b1001 for exactly one cycle.
REQ-030 Ch2 held low, reset_n pulsed low mid-count (3 cycles in) and mid-pulse (asynchronously, half a cycle after the pulse rises) -> outputs are 0 during reset, and the pulse resumes only after 7 edges post-release.
REQ-031 With DEBOUNCE_AUTOREPEAT_EN defined, REPEAT_DELAY=20 and REPEAT_PERIOD=4, ch0 held 40 cycles -> press_pulse[0] fires at the accepted press, then at +20, +24, +28, ..., and stops on release.
